// File: rtl/sclk_ctrl_pkg.sv
// Shared types and defaults for the serial-clock transfer controller.
package sclk_ctrl_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Edge counter needs one extra bit: a transfer has 2*nbits edges.
  function automatic int edge_cnt_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  localparam int ECNT_W_DEF = edge_cnt_w(CNT_W_DEF);

endpackage

// File: rtl/sclk_prescaler.sv
// Half-period prescaler: counts 0..div and ticks on the terminal value.
module sclk_prescaler
  import sclk_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             ACLK,
  input  logic             RESTN,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] presc_q, presc_d;

  assign tick_o = en_i && (presc_q == div_i);

  always_comb begin
    presc_d = presc_q;
    if (clr_i || tick_o) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = presc_q + DIV_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge RESTN) begin
    if (!RESTN) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/sclk_xfer_ctrl.sv
// Serial-clock transfer sequencer: gates SCLK for nbits cycles and strobes edges.
// Optional build macro SCLK_HOLD_EN adds hold_i to freeze timing while in RUN.
//
// state | meaning
// IDLE  | ready for start, SCLK parked at cpol
// RUN   | prescaler running, SCLK toggling
// DONE  | one-cycle completion pulse
module sclk_xfer_ctrl
  import sclk_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ACLK,
  input  logic             RESTN,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [CNT_W-1:0] nbits_i,
  input  logic             cpol_i,
`ifdef SCLK_HOLD_EN
  input  logic             hold_i,
`endif
  output logic             ready_o,
  output logic             busy_o,
  output logic             SCLK,
  output logic             lead_o,
  output logic             trail_o,
  output logic             done_o
);

  localparam int ECNT_W = edge_cnt_w(CNT_W);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  nbits_q, nbits_d;
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;
  logic              cpol_q, cpol_d;
  logic              sclk_q, sclk_d;
  logic              lead_q, lead_d;
  logic              trail_q, trail_d;
  logic              presc_en, presc_clr, tick;

`ifdef SCLK_HOLD_EN
  assign presc_en = (state_q == RUN) && !hold_i;
`else
  assign presc_en = (state_q == RUN);
`endif
  assign presc_clr = (state_q != RUN) || abort_i;

  sclk_prescaler #(.DIV_W(DIV_W)) u_presc (
    .ACLK   (ACLK),
    .RESTN  (RESTN),
    .clr_i  (presc_clr),
    .en_i   (presc_en),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    nbits_d = nbits_q;
    ecnt_d  = ecnt_q;
    cpol_d  = cpol_q;
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol_q;
        if (start_i) begin
          div_d   = div_i;
          nbits_d = nbits_i;
          cpol_d  = cpol_i;
          sclk_d  = cpol_i;
          ecnt_d  = '0;
          state_d = (nbits_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort takes priority even over the final edge.
        if (abort_i) begin
          sclk_d  = cpol_q;
          state_d = IDLE;
        end else if (tick) begin
          sclk_d  = ~sclk_q;
          ecnt_d  = ecnt_q + ECNT_W'(1);
          lead_d  = (sclk_q == cpol_q);
          trail_d = (sclk_q != cpol_q);
          if (ecnt_d == {nbits_q, 1'b0}) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge RESTN) begin
    if (!RESTN) begin
      state_q <= IDLE;
      div_q   <= '0;
      nbits_q <= '0;
      ecnt_q  <= '0;
      cpol_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      ecnt_q  <= ecnt_d;
      cpol_q  <= cpol_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign SCLK    = sclk_q;
  assign lead_o  = lead_q;
  assign trail_o = trail_q;

endmodule

// File: tb/tb_sclk_xfer_ctrl.sv
// Directed bench for sclk_xfer_ctrl; hold scenario runs when SCLK_HOLD_EN is defined.
module tb_sclk_xfer_ctrl;

  logic       ACLK = 1'b0;
  logic       RESTN = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] div_i = '0;
  logic [5:0] nbits_i = '0;
  logic       cpol_i = 1'b0;
  logic       hold_i = 1'b0;
  logic       ready_o, busy_o, SCLK, lead_o, trail_o, done_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  sclk_xfer_ctrl dut (
    .ACLK    (ACLK),
    .RESTN   (RESTN),
    .start_i (start_i),
    .abort_i (abort_i),
    .div_i   (div_i),
    .nbits_i (nbits_i),
    .cpol_i  (cpol_i),
`ifdef SCLK_HOLD_EN
    .hold_i  (hold_i),
`endif
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .SCLK    (SCLK),
    .lead_o  (lead_o),
    .trail_o (trail_o),
    .done_o  (done_o)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({ready_o, busy_o, SCLK, lead_o, trail_o, done_o} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 100000",
               {ready_o, busy_o, SCLK, lead_o, trail_o, done_o});
    end
    #20;
    RESTN = 1'b1;
    tick();
    n_cmp++;
    if ({ready_o, SCLK, done_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_release got %b want 100", {ready_o, SCLK, done_o});
    end
  endtask

  // Per-cycle model: edge k (1..2*nb) is visible at T+1+k*(dv+1), odd edges lead.
  task automatic test_xfer(input int dv, input int nb, input bit cp, input int exp_done);
    int per, k;
    bit e_edge, e_sclk;
    per = dv + 1;
    div_i   = dv[7:0];
    nbits_i = nb[5:0];
    cpol_i  = cp;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    div_i   = ~div_i;
    nbits_i = nbits_i + 6'd1;
    cpol_i  = ~cp;
    for (int c = 1; c <= exp_done + 1; c++) begin
      k = (c - 1) / per;
      if (k > 2 * nb) k = 2 * nb;
      e_edge = (c > 1) && ((c - 1) % per == 0) && ((c - 1) / per <= 2 * nb);
      e_sclk = cp ^ k[0];
      n_cmp++;
      if (SCLK !== e_sclk) begin
        n_bad++;
        $display("FAIL sclk div=%0d nb=%0d c=%0d got %b want %b", dv, nb, c, SCLK, e_sclk);
      end
      n_cmp++;
      if (lead_o !== (e_edge && k[0])) begin
        n_bad++;
        $display("FAIL lead div=%0d nb=%0d c=%0d got %b want %b", dv, nb, c, lead_o, e_edge && k[0]);
      end
      n_cmp++;
      if (trail_o !== (e_edge && !k[0])) begin
        n_bad++;
        $display("FAIL trail div=%0d nb=%0d c=%0d got %b want %b", dv, nb, c, trail_o, e_edge && !k[0]);
      end
      n_cmp++;
      if (done_o !== (c == exp_done)) begin
        n_bad++;
        $display("FAIL done div=%0d nb=%0d c=%0d got %b want %b", dv, nb, c, done_o, c == exp_done);
      end
      n_cmp++;
      if (busy_o !== (c < exp_done)) begin
        n_bad++;
        $display("FAIL busy div=%0d nb=%0d c=%0d got %b want %b", dv, nb, c, busy_o, c < exp_done);
      end
      n_cmp++;
      if (ready_o !== (c == exp_done + 1)) begin
        n_bad++;
        $display("FAIL ready div=%0d nb=%0d c=%0d got %b want %b", dv, nb, c, ready_o, c == exp_done + 1);
      end
      // A second start while not idle must be ignored.
      start_i = (c == 2) && (c < exp_done);
      if (c <= exp_done) tick();
    end
    start_i = 1'b0;
  endtask

  task automatic test_abort();
    div_i = 8'd2; nbits_i = 6'd4; cpol_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    n_cmp++;
    if ({SCLK, lead_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL abort_third_edge got %b want 01", {SCLK, lead_o});
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++;
    if ({SCLK, ready_o, busy_o, lead_o, trail_o, done_o} !== 6'b110000) begin
      n_bad++;
      $display("FAIL abort_after got %b want 110000",
               {SCLK, ready_o, busy_o, lead_o, trail_o, done_o});
    end
    nbits_i = 6'd0; cpol_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_cmp++;
    if ({done_o, SCLK} !== 2'b10) begin
      n_bad++;
      $display("FAIL restart_after_abort got %b want 10", {done_o, SCLK});
    end
    tick();
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_ready got %b want 1", ready_o);
    end
  endtask

  task automatic test_abort_final_edge();
    div_i = 8'd0; nbits_i = 6'd1; cpol_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    n_cmp++;
    if ({SCLK, lead_o} !== 2'b11) begin
      n_bad++;
      $display("FAIL abort_final_lead got %b want 11", {SCLK, lead_o});
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++;
    if ({SCLK, trail_o, done_o, ready_o} !== 4'b0001) begin
      n_bad++;
      $display("FAIL abort_final_edge got %b want 0001", {SCLK, trail_o, done_o, ready_o});
    end
    tick();
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_final_nodone got %b want 0", done_o);
    end
  endtask

  task automatic test_start_abort_idle();
    nbits_i = 6'd0; start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL start_with_abort got %b want 1", done_o);
    end
    tick();
    abort_i = 1'b0;
    n_cmp++;
    if ({ready_o, done_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_in_done got %b want 10", {ready_o, done_o});
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    seen = 0;
    div_i = 8'd4; nbits_i = 6'd8; cpol_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    #2;
    RESTN = 1'b0;
    #1;
    n_cmp++;
    if ({ready_o, busy_o, SCLK, lead_o, trail_o, done_o} !== 6'b100000) begin
      n_bad++;
      $display("FAIL async_reset_mid_run got %b want 100000",
               {ready_o, busy_o, SCLK, lead_o, trail_o, done_o});
    end
    #2;
    RESTN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_o || busy_o) seen++;
    end
    n_cmp++;
    if (seen !== 0 || SCLK !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_quiet got active=%0d sclk=%b want 0 0", seen, SCLK);
    end
  endtask

`ifdef SCLK_HOLD_EN
  task automatic test_hold();
    div_i = 8'd1; nbits_i = 6'd2; cpol_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      n_cmp++;
      if (done_o !== (c == 16)) begin
        n_bad++;
        $display("FAIL hold_done c=%0d got %b want %b", c, done_o, c == 16);
      end
      if (c >= 5 && c <= 11) begin
        n_cmp++;
        if ({SCLK, lead_o, trail_o} !== 3'b100) begin
          n_bad++;
          $display("FAIL hold_frozen c=%0d got %b want 100", c, {SCLK, lead_o, trail_o});
        end
      end
      hold_i = (c >= 4) && (c <= 10);
      tick();
    end
    hold_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_xfer(4, 8, 1'b0, 81);
    test_xfer(0, 1, 1'b1, 3);
    test_xfer(0, 0, 1'b0, 1);
    test_xfer(2, 3, 1'b1, 19);
    test_abort();
    test_abort_final_edge();
    test_start_abort_idle();
    test_reset_mid_run();
`ifdef SCLK_HOLD_EN
    test_hold();
`endif
    test_xfer(255, 63, 1'b0, 32257);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sclk_xfer_ctrl.md
Name: sclk_xfer_ctrl

Overview:
Sequences the serial-clock generator for a transfer of a fixed number of SCLK cycles.
- Accepts a start request with a per-transfer divisor, bit count and clock polarity.
- Runs the prescaler, gates SCLK, emits leading- and trailing-edge strobes for the shift logic, and pulses done at the end.
- Sits between the register/AXI front end and the serial shift datapath.

Parameters:
DIV_W, 8, width of divisor input; SCLK half-period = div_i+1 ACLK cycles
CNT_W, 6, width of bit-count input (max 2^CNT_W-1 SCLK cycles per transfer)

Ports:
ACLK  input  1  system clock, all logic on rising edge
RESTN  input  1  asynchronous active-low reset
start_i  input  1  transfer request, accepted only when ready_o=1
abort_i  input  1  terminate current transfer
div_i  input  DIV_W  half-period minus one, sampled on accept
nbits_i  input  CNT_W  SCLK cycles in transfer, sampled on accept
cpol_i  input  1  idle SCLK level, sampled on accept
ready_o  output  1  high in IDLE
busy_o  output  1  high in RUN
SCLK  output  1  gated serial clock, registered
lead_o  output  1  1-cycle strobe, cycle SCLK shows a leading edge (leaves idle level)
trail_o  output  1  1-cycle strobe, cycle SCLK shows a trailing edge (returns to idle level)
done_o  output  1  1-cycle completion pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE, SCLK=0, cpol_q=0, counters=0, busy_o/lead_o/trail_o/done_o=0, ready_o=1.
- State machine: IDLE, RUN, DONE. ready_o=(state==IDLE); busy_o=(state==RUN).
- IDLE:
  - SCLK=cpol_q.
  - start_i at cycle T latches div_q, nbits_q and cpol_q; SCLK takes the new cpol at T+1.
  - If nbits_i==0, go to DONE; otherwise go to RUN with presc=0 and edge_cnt=0.
- RUN:
  - presc increments every cycle.
  - When presc==div_q: presc<=0, SCLK<=~SCLK, and edge_cnt<=edge_cnt+1 (width CNT_W+1).
  - On the same edge, lead_o<=1 if SCLK was at cpol_q, else trail_o<=1. Strobes are coincident with the visible SCLK change.
  - When the toggle taken is edge number 2*nbits_q, go to DONE. SCLK then ends at cpol_q.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency:
  - First SCLK edge visible at T+div+2.
  - RUN lasts 2*nbits*(div+1) cycles.
  - done_o at T+1+2*nbits*(div+1); ready_o high the following cycle.
- Handshake and boundary cases:
  - start_i is ignored when ready_o=0.
  - div_i, nbits_i and cpol_i changes outside the accept cycle have no effect.
  - abort_i in RUN: next cycle SCLK=cpol_q, state=IDLE, no done_o, no strobes. abort_i wins over a simultaneous final edge.
  - abort_i in IDLE or DONE has no effect; a done pulse already in DONE still completes.
  - start_i and abort_i together in IDLE: start is accepted.
  - div_i=0: SCLK toggles every cycle, period 2 ACLK.
  - Max divisor 2^DIV_W-1 with max nbits: counters must not wrap.
  - RESTN asserted mid-RUN: immediate return to reset values, no done_o.

Optional Feature:
SCLK_HOLD_EN
- Defined: adds port hold_i (input, 1). While hold_i=1 in RUN, presc and SCLK are frozen and no strobes or edges are counted. Timing resumes exactly where it paused. hold_i is ignored outside RUN, and abort_i still works while held.
- Not defined: no hold_i port; timing is strictly as above.

Decomposition:
- Package sclk_ctrl_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - default localparams for DIV_W and CNT_W;
  - edge-count width helper constant CNT_W+1.
- One natural sub-module: sclk_prescaler, containing presc, its clear/enable and a tick output when presc==div. The FSM, SCLK register and strobes stay in the top.

Test Plan:
1. div=4, nbits=8, cpol=0, start at T -> SCLK rises at T+6, period 10, 8 lead_o and 8 trail_o strobes, done_o at T+81, SCLK=0 after.
2. div=0, nbits=1, cpol=1 -> SCLK 1->0 at T+2 (lead_o), 0->1 at T+3 (trail_o), done_o at T+3, ready_o at T+4.
3. nbits=0 -> no SCLK edges, done_o at T+1, ready_o at T+2.
4. div=2, nbits=4, abort_i after third edge -> SCLK returns to cpol next cycle, no done_o, ready_o=1; a new start is accepted immediately.
5. Second start_i and changed div_i during RUN -> ignored, original timing kept; RESTN pulsed mid-RUN -> all outputs at reset values asynchronously.
6. SCLK_HOLD_EN defined: hold_i high for 7 cycles mid-RUN -> SCLK frozen and done_o delayed by exactly 7 cycles.
